bcd_score_counter: RTL

BCD_SCORE_COUNTER -- requirements
Module: bcd_score_counter

---
 rtl/bcd_score_counter.sv | 84 ++++++++
 1 files changed

// File: rtl/bcd_score_counter.sv
// bcd_score_counter: NUM_DIGITS-digit BCD score with add/dec/load, saturating or wrapping,
// plus a registered high-score tracker and one-cycle status pulses.
module bcd_score_counter #(
   parameter int NUM_DIGITS = 4,
   parameter bit SATURATE   = 1'b1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    reconfig_i,
   input  logic                    enable_i,
   input  logic                    inc_i,
   input  logic [3:0]              add_val_i,
   input  logic                    dec_i,
   input  logic                    load_i,
   input  logic [4*NUM_DIGITS-1:0] load_val_i,
   output logic [4*NUM_DIGITS-1:0] digits_o,
   output logic [4*NUM_DIGITS-1:0] best_o,
   output logic                    overflow_o,
   output logic                    underflow_o,
   output logic                    at_zero_o,
   output logic                    err_o
);
   localparam int W = 4 * NUM_DIGITS;
   logic [W-1:0] digits_q, digits_d, best_q, best_d, sum, diff;
   logic         ovf_q, ovf_d, unf_q, unf_d, err_q, err_d;
   logic         carry, borrow, load_ok;
   logic [4:0]   s;
   always_comb begin
      carry   = 1'b0;
      borrow  = 1'b1;
      load_ok = 1'b1;
      sum     = '0;
      diff    = '0;
      s       = '0;
      // decimal carry/borrow ripple; final borrow set means the score is zero
      for (int i = 0; i < NUM_DIGITS; i++) begin
         s = {1'b0, digits_q[4*i+:4]} + {4'd0, carry} + ((i == 0) ? {1'b0, add_val_i} : 5'd0);
         carry = s > 5'd9;
         sum[4*i+:4] = carry ? 4'(s - 5'd10) : s[3:0];
         diff[4*i+:4] = (borrow && digits_q[4*i+:4] == 4'd0) ? 4'd9 : digits_q[4*i+:4] - {3'd0, borrow};
         borrow = borrow && digits_q[4*i+:4] == 4'd0;
         if (load_val_i[4*i+:4] > 4'd9) load_ok = 1'b0;
      end
      digits_d = digits_q;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      err_d    = 1'b0;
      if (reconfig_i) digits_d = '0;
      else if (enable_i && load_i) begin
         digits_d = load_ok ? load_val_i : digits_q;
         err_d    = !load_ok;
      end else if (enable_i && inc_i && !dec_i) begin
         err_d    = add_val_i > 4'd9;
         ovf_d    = !err_d && carry;
         digits_d = err_d ? digits_q : (carry && SATURATE) ? {NUM_DIGITS{4'd9}} : sum;
      end else if (enable_i && dec_i && !inc_i) begin
         unf_d    = borrow;
         digits_d = (borrow && SATURATE) ? '0 : diff;
      end
      // packed BCD orders the same as its decimal value
      best_d = (digits_d > best_q) ? digits_d : best_q;
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         digits_q <= '0;
         best_q   <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         digits_q <= digits_d;
         best_q   <= best_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
         err_q    <= err_d;
      end
   end
   assign digits_o    = digits_q;
   assign best_o      = best_q;
   assign overflow_o  = ovf_q;
   assign underflow_o = unf_q;
   assign err_o       = err_q;
   assign at_zero_o   = digits_q == '0;
endmodule
